fetch_pc: RTL and testbench

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pkg.sv | 13 +
 rtl/pc_hist_buf.sv | 37 +++
 rtl/fetch_pc.sv | 96 +++++++++
 tb/tb_fetch_pc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch state type and default constants
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int DEFAULT_STEP      = 4;
  localparam int DEFAULT_RESET_VEC = 0;

endpackage

// File: rtl/pc_hist_buf.sv
// rtl/pc_hist_buf.sv - shift register of accepted fetch addresses with indexed read
module pc_hist_buf #(
  parameter int ADDR_W     = 32,
  parameter int HIST_DEPTH = 4,
  localparam int SEL_W     = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [SEL_W-1:0]  sel,
  output logic [ADDR_W-1:0] newest,
  output logic [ADDR_W-1:0] rd_pc
);

  logic [ADDR_W-1:0] hist [HIST_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (push) begin
      hist[0] <= push_pc;
      for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign newest = hist[0];

  // Selects beyond the last entry match nothing and read as zero.
  always_comb begin
    rd_pc = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (sel == SEL_W'(i)) rd_pc = hist[i];
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - fetch program counter with IDLE/RUN/HALT control and address history
// Optional redirect alignment check: define FETCH_PC_ALIGN_CHECK_EN.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC),
  parameter int                STEP       = DEFAULT_STEP,
  parameter int                HIST_DEPTH = 4,
  localparam int               SEL_W      = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] i_addr_o,
  output logic              i_fetch_en_o,
  input  logic              i_ack_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              change_pc_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic [SEL_W-1:0]  hist_sel_i,
  output logic [ADDR_W-1:0] hist_pc_o,
  output logic              misalign_o
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, hist_head;
  logic              active, accept, bad_target;

  assign active = (state != IDLE);
  assign accept = (state == RUN) && i_ack_i && !stall_i && !change_pc_i;

`ifdef FETCH_PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
  logic misalign_q;

  assign bad_target = active && change_pc_i && (|(new_pc_i & ALIGN_MASK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= bad_target;
  end

  assign misalign_o = misalign_q;
`else
  assign bad_target = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_VEC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE:    state_nxt = halt_i ? HALT : RUN;
      RUN:     if (halt_i) state_nxt = HALT;
      HALT:    if (resume_i && !halt_i) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (bad_target) state_nxt = HALT;

    // Redirect beats stall beats ack; an ack during a halt request is still taken.
    if (active && change_pc_i) begin
      if (!bad_target) pc_nxt = new_pc_i;
    end else if (accept) begin
      pc_nxt = pc + ADDR_W'(STEP);
    end
  end

  pc_hist_buf #(
    .ADDR_W    (ADDR_W),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (accept),
    .push_pc(pc),
    .sel    (hist_sel_i),
    .newest (hist_head),
    .rd_pc  (hist_pc_o)
  );

  assign i_fetch_en_o = (state == RUN);
  assign i_addr_o     = stall_i ? hist_head : pc;

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - directed scoreboard bench for fetch_pc
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr, new_pc, hist_pc;
  logic        fetch_en, ack, change_pc, stall, halt, resume, misalign;
  logic [1:0]  hist_sel;

  logic [7:0]  addr8, new8, hist8;
  logic        fetch_en8, ack8, chg8, misalign8;
  logic [1:0]  sel8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_pc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr_o    (i_addr),
    .i_fetch_en_o(fetch_en),
    .i_ack_i     (ack),
    .new_pc_i    (new_pc),
    .change_pc_i (change_pc),
    .stall_i     (stall),
    .halt_i      (halt),
    .resume_i    (resume),
    .hist_sel_i  (hist_sel),
    .hist_pc_o   (hist_pc),
    .misalign_o  (misalign)
  );

  fetch_pc #(.ADDR_W(8), .HIST_DEPTH(3)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr_o    (addr8),
    .i_fetch_en_o(fetch_en8),
    .i_ack_i     (ack8),
    .new_pc_i    (new8),
    .change_pc_i (chg8),
    .stall_i     (1'b0),
    .halt_i      (1'b0),
    .resume_i    (1'b0),
    .hist_sel_i  (sel8),
    .hist_pc_o   (hist8),
    .misalign_o  (misalign8)
  );

  function automatic logic [31:0] observe(int sig);
    case (sig)
      0:       return i_addr;
      1:       return {31'd0, fetch_en};
      2:       return hist_pc;
      3:       return {31'd0, misalign};
      4:       return {24'd0, addr8};
      5:       return {24'd0, hist8};
      default: return {31'd0, fetch_en8};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b1; change_pc = 1'b0; stall = 1'b0; halt = 1'b0;
    resume = 1'b0; new_pc = '0; hist_sel = 2'd0;
    ack8 = 1'b0; chg8 = 1'b0; new8 = '0; sel8 = 2'd0;

    cyc(); cyc();
    expect_val("rst_en", 1, 0);
    expect_val("rst_addr", 0, 32'h0);
    expect_val("rst_hist", 2, 32'h0);
    expect_val("rst_misalign", 3, 0);
    expect_val("rst_en8", 6, 0);
    drain();

    rst_n = 1'b1;
    expect_val("idle_en", 1, 0);
    expect_val("idle_addr", 0, 32'h0);
    drain();
    cyc();
    chg8 = 1'b1; new8 = 8'hFC;
    expect_val("run_en", 1, 1);
    expect_val("run_addr0", 0, 32'h0);
    drain();
    cyc();
    chg8 = 1'b0; ack8 = 1'b1;
    expect_val("run_addr4", 0, 32'h4);
    expect_val("hist_after_0", 2, 32'h0);
    expect_val("w8_redirect", 4, 32'hFC);
    drain();
    cyc();
    ack8 = 1'b0;
    expect_val("run_addr8", 0, 32'h8);
    expect_val("hist_after_4", 2, 32'h4);
    expect_val("w8_wrap", 4, 32'h00);
    expect_val("w8_hist0", 5, 32'hFC);
    drain();
    sel8 = 2'd3;
    expect_val("w8_sel_oob", 5, 32'h0);
    drain();

    cyc(); cyc();
    ack = 1'b0;
    expect_val("noack_c1", 0, 32'h10);
    drain();
    cyc();
    expect_val("noack_c2", 0, 32'h10);
    expect_val("noack_en", 1, 1);
    drain();
    cyc();
    expect_val("noack_c3", 0, 32'h10);
    drain();
    ack = 1'b1;
    cyc();
    expect_val("ack_c4", 0, 32'h14);
    expect_val("hist_0x10", 2, 32'h10);
    drain();

    cyc(); cyc(); cyc();
    expect_val("pre_stall_pc", 0, 32'h20);
    drain();
    stall = 1'b1;
    expect_val("stall_replay", 0, 32'h1C);
    drain();
    cyc();
    expect_val("stall_hold", 0, 32'h1C);
    drain();
    stall = 1'b0; ack = 1'b0;
    expect_val("post_stall_pc", 0, 32'h20);
    drain();
    hist_sel = 2'd1;
    expect_val("hist_sel1", 2, 32'h18);
    drain();
    hist_sel = 2'd3;
    expect_val("hist_sel3", 2, 32'h10);
    drain();
    hist_sel = 2'd0;

    change_pc = 1'b1; new_pc = 32'h100; ack = 1'b1;
    cyc();
    change_pc = 1'b0; ack = 1'b0;
    expect_val("redirect_addr", 0, 32'h100);
    expect_val("redirect_nopush", 2, 32'h1C);
    drain();

    ack = 1'b1; halt = 1'b1;
    cyc();
    halt = 1'b0;
    expect_val("halt_pc_adv", 0, 32'h104);
    expect_val("halt_en", 1, 0);
    expect_val("halt_push", 2, 32'h100);
    drain();
    cyc();
    expect_val("halt_ack_ignored", 0, 32'h104);
    drain();
    ack = 1'b0; resume = 1'b1;
    cyc();
    resume = 1'b0;
    expect_val("resume_en", 1, 1);
    expect_val("resume_addr", 0, 32'h104);
    drain();

    halt = 1'b1;
    cyc();
    halt = 1'b0; change_pc = 1'b1; new_pc = 32'h200;
    cyc();
    change_pc = 1'b0;
    expect_val("halt_redirect_pc", 0, 32'h200);
    expect_val("halt_redirect_state", 1, 0);
    drain();
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    expect_val("resume2_en", 1, 1);
    drain();

    change_pc = 1'b1; new_pc = 32'h102;
    cyc();
    change_pc = 1'b0;
`ifdef FETCH_PC_ALIGN_CHECK_EN
    expect_val("misalign_pc", 0, 32'h200);
    expect_val("misalign_pulse", 3, 1);
    expect_val("misalign_halt", 1, 0);
    drain();
    cyc();
    expect_val("misalign_once", 3, 0);
    drain();
`else
    expect_val("unchecked_pc", 0, 32'h102);
    expect_val("misalign_tied", 3, 0);
    expect_val("unchecked_en", 1, 1);
    drain();
`endif

    rst_n = 1'b0;
    #2;
    expect_val("async_rst_en", 1, 0);
    expect_val("async_rst_addr", 0, 32'h0);
    expect_val("async_rst_hist", 2, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
